// File: rtl/ahb_sram_slave_if.sv
// AHB slave-side bus bundle for ahb_sram_slave.
// The master modport drives the request side and HREADYIN; the slave modport
// drives the response side.
interface ahb_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HMASTER;
  logic [3:0]  HPROT;
  logic        HMASTERLOCK;
  logic [31:0] HWDATA;
  logic        HREADYIN;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;
  logic [15:0] HSPLIT;

  modport master (
    output HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HMASTER, HPROT,
           HMASTERLOCK, HWDATA, HREADYIN,
    input  HREADY, HRESP, HRDATA, HSPLIT
  );

  modport slave (
    input  HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HMASTER, HPROT,
           HMASTERLOCK, HWDATA, HREADYIN,
    output HREADY, HRESP, HRDATA, HSPLIT
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB responder backed by a word-organised register-file memory.
// WAIT wait states per legal data phase; two-cycle ERROR for illegal sizes.
// Optional macro AHB_SLV_ALIGN_CHK_EN: unaligned half/word transfers take the
// ERROR response instead of being silently aligned.
module ahb_sram_slave #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned WAIT   = 1
) (
  input logic             HCLK,
  input logic             HRESET,
  ahb_sram_slave_if.slave bus
);

  localparam int unsigned DEPTH    = 1 << (ADDR_W - 2);
  localparam logic [2:0]  WAIT_CNT = 3'(WAIT);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_XFER, S_ERR1, S_ERR2} state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [2:0]          size_q, size_d;

  logic [31:0]         mem [DEPTH];
  logic                hready_o;
  logic [1:0]          hresp_o;
  logic                sample;
  logic                legal;
  logic [ADDR_W-1:0]   addr_in;
  logic [3:0]          be;
  logic                unused_ok;

  assign sample = bus.HSEL & bus.HREADYIN & bus.HTRANS[1];

  // Address-phase legality and the address actually stored for the data phase
  always_comb begin
    addr_in = bus.HADDR[ADDR_W-1:0];
`ifdef AHB_SLV_ALIGN_CHK_EN
    legal = (bus.HSIZE <= 3'b010) &&
            !((bus.HSIZE == 3'b001) && bus.HADDR[0]) &&
            !((bus.HSIZE == 3'b010) && (bus.HADDR[1:0] != 2'b00));
`else
    legal = (bus.HSIZE <= 3'b010);
    if (bus.HSIZE == 3'b001) addr_in[0] = 1'b0;
    if (bus.HSIZE == 3'b010) addr_in[1:0] = 2'b00;
`endif
  end

  // Next-state and response outputs; a new address phase is only taken while HREADY is high
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    write_d  = write_q;
    size_d   = size_q;
    hready_o = 1'b1;
    hresp_o  = 2'b00;
    case (state_q)
      S_WAIT: begin
        hready_o = 1'b0;
        cnt_d    = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = S_XFER;
      end
      S_ERR1: begin
        hready_o = 1'b0;
        hresp_o  = 2'b01;
        state_d  = S_ERR2;
      end
      S_ERR2: hresp_o = 2'b01;
      default: ;
    endcase
    if (hready_o) begin
      if (sample) begin
        addr_d  = addr_in;
        write_d = bus.HWRITE;
        size_d  = bus.HSIZE;
        if (!legal) begin
          state_d = S_ERR1;
        end else if (WAIT_CNT != '0) begin
          state_d = S_WAIT;
          cnt_d   = WAIT_CNT;
        end else begin
          state_d = S_XFER;
        end
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // Control registers; reset returns the outputs to idle immediately
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  // Little-endian byte-lane enables for the registered transfer
  always_comb begin
    be = 4'b1111;
    case (size_q)
      3'b000:  be = 4'b0001 << addr_q[1:0];
      3'b001:  be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Memory write at the closing edge of an OKAY write data phase (no reset)
  always_ff @(posedge HCLK) begin
    if ((state_q == S_XFER) && write_q) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[addr_q[ADDR_W-1:2]][8*i +: 8] <= bus.HWDATA[8*i +: 8];
      end
    end
  end

  assign bus.HREADY = hready_o;
  assign bus.HRESP  = hresp_o;
  assign bus.HRDATA = ((state_q == S_XFER) && !write_q) ? mem[addr_q[ADDR_W-1:2]] : '0;
  assign bus.HSPLIT = '0;

  assign unused_ok = ^{bus.HADDR[31:ADDR_W], bus.HTRANS[0], bus.HBURST,
                       bus.HMASTER, bus.HPROT, bus.HMASTERLOCK};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: three instances with WAIT = 1, 0, 3
// share one request bus; sel routes HSEL and picks which responses are watched.
module tb_ahb_sram_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ahb_sram_slave_if if0 ();
  ahb_sram_slave_if if1 ();
  ahb_sram_slave_if if2 ();

  logic [1:0]  sel = 2'd0;
  logic        b_hsel = 1'b0;
  logic [31:0] b_haddr = '0;
  logic        b_hwrite = 1'b0;
  logic [1:0]  b_htrans = 2'b00;
  logic [2:0]  b_hsize = 3'b000;
  logic [31:0] b_hwdata = '0;

  assign if0.HSEL = b_hsel && (sel == 2'd0);
  assign if1.HSEL = b_hsel && (sel == 2'd1);
  assign if2.HSEL = b_hsel && (sel == 2'd2);
  assign {if0.HADDR, if1.HADDR, if2.HADDR}       = {3{b_haddr}};
  assign {if0.HWRITE, if1.HWRITE, if2.HWRITE}    = {3{b_hwrite}};
  assign {if0.HTRANS, if1.HTRANS, if2.HTRANS}    = {3{b_htrans}};
  assign {if0.HSIZE, if1.HSIZE, if2.HSIZE}       = {3{b_hsize}};
  assign {if0.HWDATA, if1.HWDATA, if2.HWDATA}    = {3{b_hwdata}};
  assign {if0.HBURST, if1.HBURST, if2.HBURST}    = '0;
  assign {if0.HMASTER, if1.HMASTER, if2.HMASTER} = '0;
  assign {if0.HPROT, if1.HPROT, if2.HPROT}       = '0;
  assign {if0.HMASTERLOCK, if1.HMASTERLOCK, if2.HMASTERLOCK} = '0;
  assign if0.HREADYIN = if0.HREADY;
  assign if1.HREADYIN = if1.HREADY;
  assign if2.HREADYIN = if2.HREADY;

  ahb_sram_slave #(.ADDR_W(10), .WAIT(1)) u_dut0 (.HCLK(clk), .HRESET(rst), .bus(if0));
  ahb_sram_slave #(.ADDR_W(10), .WAIT(0)) u_dut1 (.HCLK(clk), .HRESET(rst), .bus(if1));
  ahb_sram_slave #(.ADDR_W(10), .WAIT(3)) u_dut2 (.HCLK(clk), .HRESET(rst), .bus(if2));

  logic        hready_m;
  logic [1:0]  hresp_m;
  logic [31:0] hrdata_m;
  always_comb begin
    case (sel)
      2'd1:    begin hready_m = if1.HREADY; hresp_m = if1.HRESP; hrdata_m = if1.HRDATA; end
      2'd2:    begin hready_m = if2.HREADY; hresp_m = if2.HRESP; hrdata_m = if2.HRDATA; end
      default: begin hready_m = if0.HREADY; hresp_m = if0.HRESP; hrdata_m = if0.HRDATA; end
    endcase
  end

  typedef struct {
    int          id;
    bit          rd;
    logic [1:0]  resp;
    int unsigned waits;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: tracks the selected slave's data phase and pops one expectation per completion
  bit          active = 0;
  bit          lo_bad = 0;
  int unsigned wcnt   = 0;
  always @(negedge clk) begin
    exp_t e;
    bit   rd_x;
    if (rst) begin
      active = 0;
    end else begin
      rd_x = active && hready_m && (q.size() > 0) && q[0].rd && (q[0].resp == 2'b00);
      if (!rd_x) chk("hrdata_zero", hrdata_m, 32'h0);
      if (active) begin
        if (!hready_m) begin
          wcnt++;
          if ((q.size() > 0) && (hresp_m !== q[0].resp)) lo_bad = 1;
        end else begin
          if (q.size() == 0) begin
            chk("unexpected_phase", 32'h1, 32'h0);
          end else begin
            e = q.pop_front();
            chk($sformatf("x%0d_resp", e.id), {30'h0, hresp_m}, {30'h0, e.resp});
            chk($sformatf("x%0d_waits", e.id), wcnt, e.waits);
            if (e.waits > 0) chk($sformatf("x%0d_lowresp", e.id), {31'h0, lo_bad}, 32'h0);
            if (e.rd && (e.resp == 2'b00)) chk($sformatf("x%0d_rdata", e.id), hrdata_m, e.data);
          end
          active = 0;
        end
      end
      if (b_hsel && b_htrans[1] && hready_m) begin
        active = 1;
        wcnt   = 0;
        lo_bad = 0;
      end
    end
  end

  task automatic wait_ready(input int id);
    int unsigned n = 0;
    @(negedge clk);
    while (!hready_m && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!hready_m) chk($sformatf("x%0d_ready_timeout", id), 32'h0, 32'h1);
  endtask

  // Issue one pipelined transfer and record what its data phase must show
  task automatic xfer(input int id, input bit w, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [1:0] er, input int unsigned ew,
                      input logic [31:0] ed);
    exp_t e;
    b_hsel = 1'b1; b_htrans = 2'b10; b_haddr = a; b_hwrite = w; b_hsize = sz;
    wait_ready(id);
    @(posedge clk); #1;
    b_hwdata = wd;
    e.id = id; e.rd = !w; e.resp = er; e.waits = ew; e.data = ed;
    q.push_back(e);
  endtask

  task automatic bus_idle();
    b_hsel = 1'b0; b_htrans = 2'b00;
    wait_ready(-1);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_hready0", {31'h0, if0.HREADY}, 32'h1);
    chk("rst_hresp0",  {30'h0, if0.HRESP},  32'h0);
    chk("rst_hrdata0", if0.HRDATA,          32'h0);
    chk("rst_hsplit0", {16'h0, if0.HSPLIT}, 32'h0);
    chk("rst_hready1", {31'h0, if1.HREADY}, 32'h1);
    chk("rst_hresp1",  {30'h0, if1.HRESP},  32'h0);
    chk("rst_hrdata2", if2.HRDATA,          32'h0);
    chk("rst_hsplit2", {16'h0, if2.HSPLIT}, 32'h0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // WAIT=1: word write then read back
    sel = 2'd0;
    xfer(1, 1, 32'h010, 3'b010, 32'hA5A5_1234, 2'b00, 1, 32'h0);
    xfer(2, 0, 32'h010, 3'b010, 32'h0,         2'b00, 1, 32'hA5A5_1234);
    bus_idle();

    // WAIT=0: four back-to-back byte writes, then word read
    sel = 2'd1;
    xfer(3, 1, 32'h020, 3'b000, 32'h0000_0011, 2'b00, 0, 32'h0);
    xfer(4, 1, 32'h021, 3'b000, 32'h0000_2200, 2'b00, 0, 32'h0);
    xfer(5, 1, 32'h022, 3'b000, 32'h0033_0000, 2'b00, 0, 32'h0);
    xfer(6, 1, 32'h023, 3'b000, 32'h4400_0000, 2'b00, 0, 32'h0);
    xfer(7, 0, 32'h020, 3'b010, 32'h0,         2'b00, 0, 32'h4433_2211);
    bus_idle();

    // WAIT=3: word write then half-word read of the upper half
    sel = 2'd2;
    xfer(8, 1, 32'h030, 3'b010, 32'hCAFE_BEEF, 2'b00, 3, 32'h0);
    xfer(9, 0, 32'h032, 3'b001, 32'h0,         2'b00, 3, 32'hCAFE_BEEF);
    bus_idle();

    // WAIT=1: illegal size takes the two-cycle ERROR and leaves memory intact
    sel = 2'd0;
    xfer(10, 1, 32'h040, 3'b010, 32'h0102_0304, 2'b00, 1, 32'h0);
    xfer(11, 1, 32'h040, 3'b011, 32'hFFFF_FFFF, 2'b01, 1, 32'h0);
    xfer(12, 0, 32'h040, 3'b010, 32'h0,         2'b00, 1, 32'h0102_0304);
    bus_idle();

    // Unaligned word write
`ifdef AHB_SLV_ALIGN_CHK_EN
    xfer(13, 1, 32'h042, 3'b010, 32'h5566_7788, 2'b01, 1, 32'h0);
    xfer(14, 0, 32'h040, 3'b010, 32'h0,         2'b00, 1, 32'h0102_0304);
`else
    xfer(13, 1, 32'h042, 3'b010, 32'h5566_7788, 2'b00, 1, 32'h0);
    xfer(14, 0, 32'h040, 3'b010, 32'h0,         2'b00, 1, 32'h5566_7788);
`endif
    bus_idle();

    // WAIT=3: reset during a write wait state aborts the write
    sel = 2'd2;
    b_hsel = 1'b1; b_htrans = 2'b10; b_haddr = 32'h030; b_hwrite = 1'b1; b_hsize = 3'b010;
    wait_ready(15);
    @(posedge clk); #1;
    b_hwdata = 32'h1234_5678; b_hsel = 1'b0; b_htrans = 2'b00;
    @(negedge clk);
    chk("wait_hready_low", {31'h0, hready_m}, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_hready", {31'h0, hready_m}, 32'h1);
    chk("rst_mid_hresp",  {30'h0, hresp_m},  32'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    xfer(16, 0, 32'h030, 3'b010, 32'h0,         2'b00, 3, 32'hCAFE_BEEF);
    xfer(17, 1, 32'h030, 3'b010, 32'h0BAD_F00D, 2'b00, 3, 32'h0);
    xfer(18, 0, 32'h030, 3'b010, 32'h0,         2'b00, 3, 32'h0BAD_F00D);
    bus_idle();

    repeat (3) @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB responder with an internal word-organised register-file memory, a programmable number of wait states and a two-cycle ERROR response for illegal transfers. It sits on the slave side of the AHB fabric, behind the address decoder that drives `HSEL`. It is the bus-target counterpart to the AHB master used in the same subsystem. It never issues SPLIT or RETRY.

## Interface
Parameters:
- `ADDR_W`, default 10: byte-address bits decoded inside the window. Memory depth is 2^(ADDR_W-2) 32-bit words. `HADDR[31:ADDR_W]` is ignored.
- `WAIT`, default 1: wait states inserted in every NONSEQ/SEQ data phase. Legal range 0..7.

Ports:
- `HCLK` in 1: bus clock. All state changes on its rising edge.
- `HRESET` in 1: reset, asynchronous, active-high.
- `HSEL` in 1: slave select from the decoder.
- `HADDR` in 32: transfer address.
- `HWRITE` in 1: 1 = write.
- `HTRANS` in 2: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `HSIZE` in 3: 000 byte, 001 half, 010 word.
- `HBURST` in 3: burst type. Accepted, not used.
- `HMASTER` in 4: current master. Accepted, not used.
- `HPROT` in 4: protection. Accepted, not used.
- `HMASTERLOCK` in 1: locked transfer. Accepted, not used.
- `HWDATA` in 32: write data, valid in the data phase.
- `HREADYIN` in 1: system HREADY; previous transfer complete.
- `HREADY` out 1: this slave's data phase complete.
- `HRESP` out 2: OKAY=00, ERROR=01.
- `HRDATA` out 32: read data.
- `HSPLIT` out 16: split-resume mask. Constant 0.

## Operation
- Address-phase sample: when `HSEL & HREADYIN & HTRANS[1]` is true at a rising edge, register `HADDR[ADDR_W-1:0]`, `HWRITE` and `HSIZE`, plus a legality flag. Enter the data phase.
- With `HSEL=0`, or with IDLE/BUSY: no data phase is created. Outputs stay `HREADY=1`, `HRESP=00`.
- States:
  - IDLE
  - WAIT (counter > 0)
  - XFER (final OKAY cycle)
  - ERR1
  - ERR2
- IDLE transitions on sample:
  - legal and WAIT>0 -> WAIT, counter loaded with WAIT.
  - legal and WAIT=0 -> XFER.
  - illegal -> ERR1.
- WAIT: `HREADY=0`, `HRESP=00`. Counter decrements each cycle; at 1 go to XFER.
- XFER: `HREADY=1`, `HRESP=00`.
  - Write: byte lanes selected by `HSIZE` and addr[1:0] (little-endian) take `HWDATA` at the closing edge.
  - Read: `HRDATA` = memory word at addr[ADDR_W-1:2], combinational from the registered address.
  - A new address phase may be sampled on the same edge (pipelined). Next state is WAIT, XFER, ERR1 or IDLE accordingly.
- ERR1: `HREADY=0`, `HRESP=01`. Go to ERR2.
- ERR2: `HREADY=1`, `HRESP=01`. The write is not performed. A new address phase may be sampled on this edge; a master cancelling with IDLE is handled by the IDLE rule.
- Illegal transfers:
  - `HSIZE > 010`.
  - With the alignment check compiled in (see Configuration): half-word with addr[0]=1, or word with addr[1:0]≠00.
- Address-phase inputs are ignored while `HREADY=0`; the master holds them.
- `HRDATA` is 0 in every cycle that is not an XFER read.
- Memory is not reset; contents are undefined after power-up.

## Timing
- Reset values: `HREADY=1`, `HRESP=00`, `HRDATA=0`, `HSPLIT=0`, state IDLE, counter 0.
- Reset asserted mid-transfer: outputs return to reset values immediately (asynchronously) and any pending write is discarded. Memory contents are kept.
- Data-phase length:
  - legal transfer: WAIT+1 cycles.
  - illegal transfer: exactly 2 cycles.
- Back-to-back NONSEQ/SEQ with WAIT=0: one transfer per cycle.
- Write then read to the same word: the read returns the new data for every WAIT value, including WAIT=0. The write commits at the edge where the read's address is sampled, and the read data is produced one cycle later.
- Burst address wrap/increment is the master's responsibility; each beat is treated independently.

## Configuration
- `AHB_SLV_ALIGN_CHK_EN` defined: unaligned half-word/word transfers take the two-cycle ERROR and no write occurs.
- Not defined: address low bits are forced to the natural alignment of `HSIZE`. The transfer completes OKAY, and only `HSIZE > 010` produces ERROR.

## Test plan
- Reset, WAIT=1: word write 0xA5A5_1234 to 0x010, then word read of 0x010 -> write phase `HREADY` low 1 cycle; read returns 0xA5A5_1234 with `HRESP=00`.
- WAIT=0: byte writes 0x11, 0x22, 0x33, 0x44 to 0x20–0x23, issued back to back, then word read -> 0x4433_2211; 5 transfers in 5 consecutive cycles; `HREADY` never low.
- WAIT=3: half-word read -> exactly 3 cycles of `HREADY=0` then 1 OKAY cycle; `HRDATA`=0 outside that cycle.
- `HSIZE=011` write to 0x040 -> `HREADY=0/HRESP=01`, then `HREADY=1/HRESP=01`; a later read of 0x040 is unchanged.
- Word write to 0x042:
  - with `AHB_SLV_ALIGN_CHK_EN` -> 2-cycle ERROR.
  - without -> OKAY and the word at 0x040 is written.
- `HRESET` pulsed during a WAIT cycle of a write -> `HREADY=1`, `HRESP=00` immediately; the target word is unchanged; the next transfer behaves normally.
